// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM for a multicycle datapath.
//
// Sequences each instruction through FETCH / DECODE / execute / writeback and
// produces every datapath enable and mux select, plus the {aluop, funct_out}
// pair consumed by the ALU decoder. Memory accesses stall on mem_ready.
//
// Optional build macro: ILLEGAL_OP_TRAP_EN
//   defined   : illegal opcodes and R-type funct > 0100 trap into a sticky
//               HALT state (12) that raises `illegal` until reset.
//   undefined : illegal opcodes retire as a NOP; `illegal` is tied 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (forces FETCH, clears op_q)
//   op, funct  instruction fields from the IR
//   mem_ready  memory completes the current read/write this cycle
//   zero       ALU zero flag (branch decision)
//   irwrite .. pcsrc   datapath enables / selects
//   aluop, funct_out   ALU decoder control
//   state      current state (debug)
//   illegal    illegal-instruction flag
module multicycle_ctrl #(
  parameter int OPW = 4,
  parameter int FW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [OPW-1:0] op,
  input  logic [FW-1:0]  funct,
  input  logic          mem_ready,
  input  logic          zero,
  output logic          irwrite,
  output logic          pcen,
  output logic          iord,
  output logic          memread,
  output logic          memwrite,
  output logic          regwrite,
  output logic          regdst,
  output logic          memtoreg,
  output logic          alusrca,
  output logic [1:0]    alusrcb,
  output logic [1:0]    pcsrc,
  output logic [1:0]    aluop,
  output logic [FW-1:0] funct_out,
  output logic [3:0]    state,
  output logic          illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
    ,S_HALT   = 4'd12
`endif
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
  localparam logic [OPW-1:0] OP_LW    = OPW'(1);
  localparam logic [OPW-1:0] OP_SW    = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(3);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(4);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(5);
  localparam logic [OPW-1:0] OP_J     = OPW'(6);

  localparam logic [1:0] ALU_ADD   = 2'b11;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b00;

  state_t         st, st_nxt;
  logic [OPW-1:0] op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= S_FETCH;
      op_q <= '0;
    end else begin
      st <= st_nxt;
      if (st == S_DECODE) op_q <= op;
    end
  end

  assign state = st;

  always_comb begin
    irwrite   = 1'b0;
    pcen      = 1'b0;
    iord      = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    aluop     = 2'b00;
    funct_out = '0;
    illegal   = 1'b0;
    st_nxt    = S_FETCH;

    case (st)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        aluop   = ALU_ADD;
        // While reset is held the state already reads FETCH; the fetch must
        // not be committed until reset has gone away.
        if (mem_ready && !reset) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          st_nxt  = S_DECODE;
        end else begin
          st_nxt  = S_FETCH;
        end
      end

      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = ALU_ADD;
        // Dispatch on the live IR field; op_q is being captured this cycle.
        case (op)
          OP_LW, OP_SW:      st_nxt = S_MEMADR;
`ifdef ILLEGAL_OP_TRAP_EN
          OP_RTYPE:          st_nxt = (funct > FW'(4)) ? S_HALT : S_EXECUTE;
`else
          OP_RTYPE:          st_nxt = S_EXECUTE;
`endif
          OP_BEQ:            st_nxt = S_BRANCH;
          OP_ADDI, OP_SLTI:  st_nxt = S_IMMEX;
          OP_J:              st_nxt = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:           st_nxt = S_HALT;
`else
          default:           st_nxt = S_FETCH;
`endif
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALU_ADD;
        st_nxt  = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        st_nxt  = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        st_nxt   = S_FETCH;
      end

      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        st_nxt   = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXECUTE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b00;
        aluop     = ALU_FUNCT;
        funct_out = funct;
        st_nxt    = S_ALUWB;
      end

      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        st_nxt   = S_FETCH;
      end

      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = zero;
        st_nxt  = S_FETCH;
      end

      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
        st_nxt  = S_IMMWB;
      end

      S_IMMWB: begin
        regwrite = 1'b1;
        st_nxt   = S_FETCH;
      end

      S_JUMP: begin
        pcsrc  = 2'b10;
        pcen   = 1'b1;
        st_nxt = S_FETCH;
      end

`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT: begin
        illegal = 1'b1;
        st_nxt  = S_HALT;
      end
`endif

      default: st_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and compares state, illegal and a packed control vector
// against hand-written expected values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, mem_ready, zero;
  logic [3:0] op, funct;
  logic       irwrite, pcen, iord, memread, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] funct_out, state;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPW(4), .FW(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready), .zero(zero),
    .irwrite(irwrite), .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .funct_out(funct_out),
    .state(state), .illegal(illegal)
  );

  // {irwrite,pcen,iord,memread,memwrite,regwrite,regdst,memtoreg,alusrca,
  //  alusrcb,pcsrc,aluop,funct_out}
  wire [18:0] ctl = {irwrite, pcen, iord, memread, memwrite, regwrite, regdst, memtoreg,
                     alusrca, alusrcb, pcsrc, aluop, funct_out};

  localparam logic [18:0] C_F_RDY  = 19'b110100000_01_00_11_0000;
  localparam logic [18:0] C_F_WAIT = 19'b000100000_01_00_11_0000;
  localparam logic [18:0] C_DEC    = 19'b000000000_11_00_11_0000;
  localparam logic [18:0] C_MADR   = 19'b000000001_10_00_11_0000;
  localparam logic [18:0] C_MRD    = 19'b001100000_00_00_00_0000;
  localparam logic [18:0] C_MWB    = 19'b000001010_00_00_00_0000;
  localparam logic [18:0] C_MWR    = 19'b001010000_00_00_00_0000;
  localparam logic [18:0] C_EXE1   = 19'b000000001_00_00_00_0001;
  localparam logic [18:0] C_ALUWB  = 19'b000001100_00_00_00_0000;
  localparam logic [18:0] C_BR_Z1  = 19'b010000001_00_01_10_0000;
  localparam logic [18:0] C_BR_Z0  = 19'b000000001_00_01_10_0000;
  localparam logic [18:0] C_IMM_AD = 19'b000000001_10_00_11_0000;
  localparam logic [18:0] C_IMM_SL = 19'b000000001_10_00_01_0000;
  localparam logic [18:0] C_IMMWB  = 19'b000001000_00_00_00_0000;
  localparam logic [18:0] C_JUMP   = 19'b010000000_00_10_00_0000;
  localparam logic [18:0] C_NONE   = 19'b000000000_00_00_00_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Check the current cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input int exp_st, input logic [18:0] exp_ctl,
                      input logic exp_ill);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(exp_st));
    chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
    chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = 4'd0; funct = 4'd0;

    // Reset: FETCH outputs, but no fetch commit even with mem_ready high.
    #12;
    chk("rst.state", 32'(state), 0);
    chk("rst.ctl", 32'(ctl), 32'(C_F_WAIT));
    chk("rst.illegal", 32'(illegal), 0);
    reset = 1'b0;

    // R-type sub: 0,1,6,7
    op = 4'd0; funct = 4'd1;
    step("r.f", 0, C_F_RDY, 1'b0);
    step("r.dec", 1, C_DEC, 1'b0);
    step("r.exe", 6, C_EXE1, 1'b0);
    step("r.wb", 7, C_ALUWB, 1'b0);

    // lw with 3 memory wait cycles; op changes after DECODE to prove op_q is used.
    op = 4'd1;
    step("lw.f", 0, C_F_RDY, 1'b0);
    step("lw.dec", 1, C_DEC, 1'b0);
    op = 4'd2;
    step("lw.adr", 2, C_MADR, 1'b0);
    mem_ready = 1'b0;
    step("lw.rd0", 3, C_MRD, 1'b0);
    step("lw.rd1", 3, C_MRD, 1'b0);
    step("lw.rd2", 3, C_MRD, 1'b0);
    mem_ready = 1'b1;
    step("lw.rd3", 3, C_MRD, 1'b0);
    step("lw.wb", 4, C_MWB, 1'b0);

    // beq taken then not taken
    op = 4'd3; zero = 1'b1;
    step("beq1.f", 0, C_F_RDY, 1'b0);
    step("beq1.dec", 1, C_DEC, 1'b0);
    step("beq1.br", 8, C_BR_Z1, 1'b0);
    zero = 1'b0;
    step("beq0.f", 0, C_F_RDY, 1'b0);
    step("beq0.dec", 1, C_DEC, 1'b0);
    step("beq0.br", 8, C_BR_Z0, 1'b0);

    // addi / slti, IR changed after DECODE
    op = 4'd4;
    step("addi.f", 0, C_F_RDY, 1'b0);
    step("addi.dec", 1, C_DEC, 1'b0);
    op = 4'd5;
    step("addi.ex", 9, C_IMM_AD, 1'b0);
    step("addi.wb", 10, C_IMMWB, 1'b0);
    op = 4'd5;
    step("slti.f", 0, C_F_RDY, 1'b0);
    step("slti.dec", 1, C_DEC, 1'b0);
    op = 4'd4;
    step("slti.ex", 9, C_IMM_SL, 1'b0);
    step("slti.wb", 10, C_IMMWB, 1'b0);

    // j
    op = 4'd6;
    step("j.f", 0, C_F_RDY, 1'b0);
    step("j.dec", 1, C_DEC, 1'b0);
    step("j.jmp", 11, C_JUMP, 1'b0);

    // sw stalled, then reset mid-MEMWR
    op = 4'd2;
    step("sw.f", 0, C_F_RDY, 1'b0);
    step("sw.dec", 1, C_DEC, 1'b0);
    step("sw.adr", 2, C_MADR, 1'b0);
    mem_ready = 1'b0;
    step("sw.wr0", 5, C_MWR, 1'b0);
    #1;
    chk("sw.wr1.state", 32'(state), 5);
    chk("sw.wr1.ctl", 32'(ctl), 32'(C_MWR));
    mem_ready = 1'b1; reset = 1'b1;
    #1;
    chk("swrst.state", 32'(state), 0);
    chk("swrst.memwrite", 32'(memwrite), 0);
    chk("swrst.ctl", 32'(ctl), 32'(C_F_WAIT));
    @(posedge clk); #1;
    chk("swrst.hold", 32'(state), 0);
    reset = 1'b0;
    step("swrel.f", 0, C_F_RDY, 1'b0);
    chk("swrel.dec", 32'(state), 1);
    reset = 1'b1; #2; reset = 1'b0;

    // Illegal opcode 1111
    op = 4'hF;
    step("ill.f", 0, C_F_RDY, 1'b0);
    step("ill.dec", 1, C_DEC, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 10; i++) step("ill.halt", 12, C_NONE, 1'b1);
    reset = 1'b1; #1;
    chk("ill.rst.state", 32'(state), 0);
    chk("ill.rst.illegal", 32'(illegal), 0);
    #1; reset = 1'b0;
    // R-type with funct beyond slt also traps
    op = 4'd0; funct = 4'd5;
    step("badf.f", 0, C_F_RDY, 1'b0);
    step("badf.dec", 1, C_DEC, 1'b0);
    step("badf.halt", 12, C_NONE, 1'b1);
    reset = 1'b1; #2; reset = 1'b0;
`else
    step("ill.nop", 0, C_F_RDY, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle main control FSM. Produces the {aluop, funct} pair consumed by the ALU decoder, plus all datapath enables and mux selects.
- Sits between the instruction register (op/funct fields) and the datapath. Sequences each instruction through FETCH/DECODE/execute/writeback states.
- Stalls on memory with a mem_ready handshake.

Parameters:
- OPW, 4, opcode field width (fixed encoding below assumes 4)
- FW, 4, funct field width; drives funct_out width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  OPW  opcode from IR: 0000 R-type, 0001 lw, 0010 sw, 0011 beq, 0100 addi, 0101 slti, 0110 j, others illegal
- funct  in  FW  R-type function: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt
- mem_ready  in  1  memory completes the current read/write this cycle
- zero  in  1  ALU zero flag
- irwrite  out  1  load instruction register
- pcen  out  1  PC write enable
- iord  out  1  memory address select (0 = PC, 1 = ALUOut)
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- regwrite  out  1  register file write enable
- regdst  out  1  write-register select (1 = rd)
- memtoreg  out  1  writeback source (1 = memory data)
- alusrca  out  1  ALU A select (0 = PC, 1 = rs)
- alusrcb  out  2  ALU B select: 00 rt, 01 const 1, 10 imm, 11 branch offset
- pcsrc  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
- aluop  out  2  to ALU decoder: 11 add, 10 sub, 01 slt, 00 use funct
- funct_out  out  FW  to ALU decoder; equals funct in EXECUTE, 0000 in all other states
- state  out  4  current state, for debug/visibility
- illegal  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- Moore FSM with a 4-bit state register and a registered op_q (latched from op in DECODE only). Outputs are combinational from state; pcen and irwrite also depend on mem_ready/zero.
- Unlisted outputs are 0 in each state.
- FETCH(0): memread=1, alusrcb=01, aluop=11.
  - mem_ready=0: irwrite=pcen=0; stay in FETCH.
  - mem_ready=1: irwrite=pcen=1; go to DECODE.
- DECODE(1): alusrcb=11, aluop=11; latch op_q. Next state by op:
  - lw/sw -> MEMADR
  - R-type -> EXECUTE
  - beq -> BRANCH
  - addi/slti -> IMMEX
  - j -> JUMP
  - illegal -> FETCH (NOP)
- MEMADR(2): alusrca=1, alusrcb=10, aluop=11. op_q lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): iord=1, memread=1. Hold until mem_ready, then go to MEMWB.
- MEMWB(4): memtoreg=1, regwrite=1 -> FETCH.
- MEMWR(5): iord=1, memwrite=1, held every waiting cycle. mem_ready -> FETCH.
- EXECUTE(6): alusrca=1, alusrcb=00, aluop=00, funct_out=funct -> ALUWB.
- ALUWB(7): regdst=1, regwrite=1 -> FETCH.
- BRANCH(8): alusrca=1, aluop=10, pcsrc=01, pcen=zero -> FETCH.
- IMMEX(9): alusrca=1, alusrcb=10; aluop=11 if op_q=addi, 01 if slti -> IMMWB.
- IMMWB(10): regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP(11): pcsrc=10, pcen=1 -> FETCH.
- Unused encodings (12-15, or 13-15 with the macro) -> FETCH next cycle, all enables 0.
- Resulting {aluop, funct_out} codes: add 110000, sub 100000, slt 010000, R-type 00ffff.
- Reset:
  - Asserting reset forces state=FETCH and op_q=0 immediately, mid-instruction included.
  - While reset is high: irwrite=pcen=memwrite=regwrite=0 regardless of mem_ready. memread=1, aluop=11, alusrcb=01, illegal=0.
  - The first fetch is accepted on the first clk edge after reset deasserts with mem_ready=1.
- Latency in cycles, excluding memory wait cycles:
  - lw 5; sw 4; R-type 4; addi/slti 4; beq 3; j 3.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - DECODE with illegal op, or R-type with funct > 0100, goes to HALT(12).
  - HALT asserts illegal=1 with all enables 0, and is sticky until reset.
- Undefined:
  - No HALT state; illegal tied 0.
  - Illegal op is a NOP (DECODE -> FETCH).
  - R-type funct is not checked.

Test Plan:
- Reset high mid-MEMWR, then released with mem_ready=1 -> memwrite drops in the same cycle; state=0; DECODE after one edge.
- R-type op=0000, funct=0001, mem_ready=1 -> states 0,1,6,7,0; in EXECUTE {aluop,funct_out}=000001; regwrite=1 and regdst=1 only in ALUWB.
- lw with mem_ready low for 3 cycles in MEMRD -> memread/iord held 3 extra cycles; MEMWB only after mem_ready; total 8 cycles.
- beq with zero=1, then zero=0 -> pcen=1/pcsrc=01 in BRANCH; then pcen=0; aluop=10 in BRANCH both times.
- slti vs addi -> aluop=01 vs 11 in IMMEX; IMMWB regwrite=1, regdst=0.
- op=1111 -> with ILLEGAL_OP_TRAP_EN: state=12, illegal=1, held 10 cycles until reset. Without the macro: back to FETCH, illegal=0.
